// File: rtl/piccolo128_pkg.sv
// Shared constants, types and round-constant helper for the Piccolo-128 key schedule.
package piccolo128_pkg;

   localparam int          NROUNDS    = 31;
   localparam logic [4:0]  LAST_ROUND = 5'(NROUNDS - 1);
   localparam logic [31:0] CON_MASK   = 32'h6547a98b;

   typedef logic [15:0] key_word_t;
   typedef enum logic { IDLE, RUN } state_t;

   // new k[i] = old k[PERM[i]]
   localparam logic [2:0] PERM [8] = '{3'd2, 3'd1, 3'd6, 3'd7, 3'd0, 3'd3, 3'd4, 3'd5};

   function automatic logic [31:0] con_pair(input logic [4:0] r);
      logic [4:0] c;
      c = r + 5'd1;
      return {c, 5'b0, c, 2'b00, c, 5'b0, c} ^ CON_MASK;
   endfunction

endpackage

// File: rtl/piccolo128_con_gen.sv
// Round-constant generator: round index r -> masked 32-bit constant pair.
module piccolo128_con_gen
   import piccolo128_pkg::*;
(
   input  logic [4:0]  round,
   output logic [31:0] con32
);

   assign con32 = con_pair(round);

endmodule

// File: rtl/piccolo128_keysched.sv
// Runtime-loadable Piccolo-128 key schedule streaming 31 round-key pairs plus whitening keys.
// Optional build macro PICCOLO128_KS_ZEROIZE_EN clears key and whitening state after the final pair.
module piccolo128_keysched
   import piccolo128_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [31:0]  rk_out,
   output logic [4:0]   rk_round,
   output logic         rk_last,
   output logic [63:0]  wk_out
);

   state_t      state;
   key_word_t   key_reg [8];
   key_word_t   key_in  [8];
   logic [63:0] wk_reg;
   logic [4:0]  round;
   logic [31:0] con32;
   logic [2:0]  idx_a;
   logic [2:0]  idx_b;
   logic        handshake;

   piccolo128_con_gen u_con_gen (
      .round (round),
      .con32 (con32)
   );

   // k0 occupies the most significant word of the key bus
   always_comb begin
      for (int i = 0; i < 8; i++) key_in[i] = key[16*(7-i) +: 16];
   end

   // The register is permuted ahead of time, so the pair always sits at (2r+2, 2r+3) mod 8.
   assign idx_a     = {round[1:0], 1'b0} + 3'd2;
   assign idx_b     = idx_a | 3'd1;
   assign handshake = rk_valid & rk_ready;

   assign rk_out   = rk_valid ? {key_reg[idx_a] ^ con32[31:16], key_reg[idx_b] ^ con32[15:0]} : '0;
   assign rk_round = round;
   assign wk_out   = wk_reg;

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         // NOTE: the key register array is small and holds secret material, so it is reset explicitly.
         for (int i = 0; i < 8; i++) key_reg[i] <= '0;
         wk_reg   <= '0;
         round    <= '0;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         rk_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  for (int i = 0; i < 8; i++) key_reg[i] <= key_in[i];
                  wk_reg   <= {key_in[0][15:8], key_in[1][7:0], key_in[1][15:8], key_in[0][7:0],
                               key_in[4][15:8], key_in[7][7:0], key_in[7][15:8], key_in[4][7:0]};
                  round    <= '0;
                  busy     <= 1'b1;
                  rk_valid <= 1'b1;
                  rk_last  <= 1'b0;
               end
            end
            RUN: begin
               if (handshake) begin
                  if (round == LAST_ROUND) begin
                     state    <= IDLE;
                     busy     <= 1'b0;
                     rk_valid <= 1'b0;
                     rk_last  <= 1'b0;
`ifdef PICCOLO128_KS_ZEROIZE_EN
                     for (int i = 0; i < 8; i++) key_reg[i] <= '0;
                     wk_reg <= '0;
`endif
                  end else begin
                     round   <= round + 5'd1;
                     rk_last <= (round == LAST_ROUND - 5'd1);
                     if (round[1:0] == 2'd2) begin
                        for (int i = 0; i < 8; i++) key_reg[i] <= key_reg[PERM[i]];
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piccolo128_keysched.sv
// Randomized self-checking bench for piccolo128_keysched against a word-level schedule model.
module tb_piccolo128_keysched;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [127:0] key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [31:0]  rk_out;
   logic [4:0]   rk_round;
   logic         rk_last;
   logic [63:0]  wk_out;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_rk [31];
   logic [63:0] exp_wk;

   localparam logic [127:0] KEY_A = 128'h00112233445566778899aabbccddeeff;

   piccolo128_keysched dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .key      (key),
      .busy     (busy),
      .rk_valid (rk_valid),
      .rk_ready (rk_ready),
      .rk_out   (rk_out),
      .rk_round (rk_round),
      .rk_last  (rk_last),
      .wk_out   (wk_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference schedule: walk the rounds on an 8-word array, reordering after pairs 2, 6, ..., 26.
   task automatic build_model(input logic [127:0] k);
      logic [15:0] w [8];
      logic [15:0] t [8];
      logic [31:0] c;
      logic [31:0] con;
      for (int i = 0; i < 8; i++) w[i] = k[127 - 16*i -: 16];
      exp_wk = {w[0][15:8], w[1][7:0], w[1][15:8], w[0][7:0],
                w[4][15:8], w[7][7:0], w[7][15:8], w[4][7:0]};
      for (int r = 0; r < 31; r++) begin
         c   = 32'(r + 1);
         con = ((c << 27) | (c << 17) | (c << 10) | c) ^ 32'h6547a98b;
         exp_rk[r] = {w[(2*r + 2) % 8] ^ con[31:16], w[(2*r + 3) % 8] ^ con[15:0]};
         if ((r + 1) % 4 == 3) begin
            t = w;
            w[0] = t[2]; w[1] = t[1]; w[2] = t[6]; w[3] = t[7];
            w[4] = t[0]; w[5] = t[3]; w[6] = t[4]; w[7] = t[5];
         end
      end
   endtask

   task automatic check_idle_reset(input string tag);
      check({tag, "_busy"},  64'(busy),     64'd0);
      check({tag, "_valid"}, 64'(rk_valid), 64'd0);
      check({tag, "_last"},  64'(rk_last),  64'd0);
      check({tag, "_rk"},    64'(rk_out),   64'd0);
      check({tag, "_round"}, 64'(rk_round), 64'd0);
      check({tag, "_wk"},    wk_out,        64'd0);
   endtask

   // One key run; all driving and sampling on the falling edge.
   // random_ready: pseudo-random backpressure; inject_r: round at which a stray start is raised;
   // abort_r: round at which reset is pulsed; golden: also compare against the known-answer pairs.
   task automatic run(input logic [127:0] k, input bit random_ready, input int inject_r,
                      input int abort_r, input bit golden);
      int r = 0;
      int cycles = 0;
      build_model(k);
      start = 1'b1;
      key   = k;
      rk_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      key   = {$urandom, $urandom, $urandom, $urandom};
      while (r < 31 && cycles < 400) begin
         check("busy",     64'(busy),     64'd1);
         check("valid",    64'(rk_valid), 64'd1);
         check("round",    64'(rk_round), 64'(r));
         check("rk",       64'(rk_out),   64'(exp_rk[r]));
         check("last",     64'(rk_last),  64'(r == 30));
         check("wk",       wk_out,        exp_wk);
         if (golden && r == 0) begin
            check("gold_rk0", 64'(rk_out), 64'h2910cbfd);
            check("gold_wk",  wk_out,      64'h0033221188ffee99);
         end
         if (golden && r == 1) check("gold_rk1", 64'(rk_out), 64'hfdda0b32);
         if (r == abort_r) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            rk_ready = 1'b0;
            check_idle_reset("abort");
            return;
         end
         rk_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (r == inject_r) begin
            start = 1'b1;
            key   = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
         start = 1'b0;
         if (rk_ready) r++;
         cycles++;
      end
      rk_ready = 1'b0;
      check("run_done", 64'(r), 64'd31);
      check("end_busy",  64'(busy),     64'd0);
      check("end_valid", 64'(rk_valid), 64'd0);
      check("end_last",  64'(rk_last),  64'd0);
`ifdef PICCOLO128_KS_ZEROIZE_EN
      check("zero_rk", 64'(rk_out), 64'd0);
      check("zero_wk", wk_out,      64'd0);
      for (int i = 0; i < 8; i++) check("zero_key", 64'(dut.key_reg[i]), 64'd0);
`else
      check("keep_wk", wk_out, exp_wk);
`endif
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      key      = '0;
      rk_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_reset("reset");
      reset = 1'b0;
      @(negedge clk);

      run(KEY_A, 1'b0, -1, -1, 1'b1);
      run(KEY_A, 1'b1, -1, -1, 1'b0);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 10, -1, 1'b0);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 30, -1, 1'b0);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 15, 1'b0);
      run({$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, -1, 1'b0);
      run(KEY_A, 1'b0, -1, -1, 1'b0);
`ifndef PICCOLO128_KS_ZEROIZE_EN
      check("final_wk", wk_out, 64'h0033221188ffee99);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
